sar_search: RTL and testbench
=============================

SAR_SEARCH -- requirements
Module: sar_search

Interface
REQ-001 Parameter: WIDTH, default 4, bit width of the searched operand, trial value and result.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous and active-high.
REQ-004 Port: start  input  1  request a new search; sampled only in IDLE.
REQ-005 Port: greater  input  1  result of an external comparator evaluating (a > trial) on the current trial; combinational, valid in the same cycle as trial.
REQ-006 Port: trial  output  WIDTH  registered candidate value driven to the comparator's b operand.
REQ-007 Port: busy  output  1  high while a search is in progress.
REQ-008 Port: done  output  1  one-cycle pulse marking a new valid result.
REQ-009 Port: result  output  WIDTH  recovered value of a; held until the next completed search.

Function
REQ-010 The block SHALL recover the unknown operand a from greater alone, MSB-first, one bit per clock, WIDTH search cycles.
REQ-011 The FSM SHALL have exactly two states: IDLE and SEARCH; the bit index k SHALL count WIDTH-1 down to 0.
REQ-012 IDLE, start=1 at edge N: state becomes SEARCH, k=WIDTH-1, busy=1, done=0, trial={0, all ones below}, i.e. 0111 for WIDTH=4.
REQ-013 IDLE, start=0: state, trial, result hold; done=0.
REQ-014 Trial rule: trial = decided upper bits, 0 at bit k, ones in bits k-1..0; a > trial if and only if bit k of a is 1.
REQ-015 Each SEARCH edge SHALL sample greater: bit k is decided as greater, k decrements, and trial is rebuilt per REQ-014 for the new k.
REQ-016 At the edge sampling k=0 (edge N+WIDTH): result=all decided bits, done=1, busy=0, trial=0, state returns to IDLE.
REQ-017 Latency: start sampled at edge N gives result and done after edge N+WIDTH; done SHALL be high for exactly one cycle.
REQ-018 start during SEARCH SHALL be ignored, with no restart and no queuing.
REQ-019 start held high continuously SHALL produce back-to-back searches; the next search starts at edge N+WIDTH+1, the same edge that clears done.
REQ-020 Arithmetic is unsigned; result range is 0..2^WIDTH-1 with no wrap-around; a=0 and a=2^WIDTH-1 SHALL resolve correctly.
REQ-021 result SHALL change only at the completion edge; it SHALL NOT show partial values during SEARCH.
REQ-022 busy and done SHALL never be high in the same cycle.

Reset
REQ-023 rst=1 SHALL immediately, independent of clk, force: state=IDLE, k=WIDTH-1, trial=0, busy=0, done=0, result=0.
REQ-024 Reset during SEARCH SHALL abandon the search with no done pulse; result SHALL be 0, not a partial value.
REQ-025 After rst deasserts, the first start SHALL behave exactly per REQ-012.

Verification (WIDTH=4; the bench models greater = (a > trial) combinationally)
REQ-026 a=9, start pulse: trial sequence 7, 11, 9, 8 on successive cycles -> result=9, done pulse 4 cycles after the start edge, busy high for 4 cycles.
REQ-027 a=0: trials 7, 3, 1, 0 -> result=0; a=15: trials 7, 11, 13, 14 -> result=15.
REQ-028 Sweep a=0..15, one search each -> result==a every time, done one cycle per search, busy and done never both high.
REQ-029 start held high for 3 searches with a=5, then a=10 -> results 5 and 10 at 5-cycle spacing; start pulses during SEARCH are ignored and the search count is unchanged.
REQ-030 rst asserted mid-cycle after 2 search cycles (a=6) -> all outputs 0 immediately with no done pulse; a following start with a=6 -> result=6.

Source files
------------

// File: rtl/sar_search.sv
// Successive-approximation search: recovers an unknown operand a, MSB first,
// from an external comparator that reports (a > trial) each cycle.
module sar_search #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             greater,
  output logic [WIDTH-1:0] trial,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned KW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] ONES = '1;
  localparam logic [KW-1:0] K_TOP = KW'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    SEARCH
  } state_t;

  state_t           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic [KW-1:0]    k_m1;
  logic [WIDTH-1:0] trial_d;
  logic [WIDTH-1:0] decided;
  logic [WIDTH-1:0] result_d;
  logic             busy_d;
  logic             done_d;

  // State and output registers; reset abandons any search in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= K_TOP;
      trial   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      trial   <= trial_d;
      busy    <= busy_d;
      done    <= done_d;
      result  <= result_d;
    end
  end

  // Next-state and next-output logic; trial doubles as the decided-bit store
  // because its upper bits are exactly the bits already resolved.
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    trial_d  = trial;
    busy_d   = busy;
    done_d   = 1'b0;
    result_d = result;
    k_m1     = k_q - KW'(1);
    decided  = trial;
    decided[k_q] = greater;

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          state_d = SEARCH;
          k_d     = K_TOP;
          trial_d = ONES >> 1;
          busy_d  = 1'b1;
        end
      end
      SEARCH: begin
        if (k_q == '0) begin
          result_d = decided;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          trial_d  = '0;
          k_d      = K_TOP;
          state_d  = IDLE;
        end else begin
          // Bits below k are already ones, so only bit k-1 needs clearing.
          trial_d       = decided;
          trial_d[k_m1] = 1'b0;
          k_d           = k_m1;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_sar_search.sv
// Scoreboard bench for sar_search: stimulus pushes expected results, a
// negedge monitor pops them whenever done is seen.
module tb_sar_search;

  localparam int unsigned W = 4;

  logic         clk;
  logic         rst;
  logic         start;
  logic         greater;
  logic [W-1:0] trial;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic [W-1:0] a;

  int vectors;
  int errors;
  int searches;
  int dones;
  logic [W-1:0] expq[$];
  logic [W-1:0] prev_result;

  sar_search #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .greater(greater),
    .trial(trial),
    .busy(busy),
    .done(done),
    .result(result)
  );

  // External comparator
  assign greater = (a > trial);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input bit ok, input string name, input int act, input int exp);
    vectors++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference trial: bits above k from a, 0 at k, ones below.
  function automatic int model_trial(input int av, input int k);
    return ((av >> (k + 1)) << (k + 1)) | ((1 << k) - 1);
  endfunction

  // Monitor: invariants every cycle, scoreboard pop on done.
  always @(negedge clk) begin
    if (!rst) begin
      chk(!(busy && done), "busy_done_overlap", int'({busy, done}), 2);
      if (!done)
        chk(result == prev_result, "result_stable", int'(result), int'(prev_result));
      if (done) begin
        dones++;
        if (expq.size() == 0) begin
          chk(1'b0, "unexpected_done", int'(result), -1);
        end else begin
          logic [W-1:0] e;
          e = expq.pop_front();
          chk(result == e, "result", int'(result), int'(e));
        end
      end
    end
    prev_result = result;
  end

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk(1'b0, "idle_timeout", n, 50);
  endtask

  // Trial sequence and completion timing of a search whose start edge is next.
  task automatic follow_search(input logic [W-1:0] av, input bit poke);
    @(posedge clk);
    #1 start = 1'b0;
    for (int j = 0; j < int'(W); j++) begin
      @(negedge clk);
      chk(busy == 1'b1, "busy_during_search", int'(busy), 1);
      chk(int'(trial) == model_trial(int'(av), int'(W) - 1 - j), "trial",
          int'(trial), model_trial(int'(av), int'(W) - 1 - j));
      start = (poke && j == 1);
    end
    start = 1'b0;
    @(negedge clk);
    chk(done && !busy && trial == '0, "completion", int'({done, busy, trial}),
        int'({1'b1, 1'b0, {W{1'b0}}}));
  endtask

  task automatic run_search(input logic [W-1:0] av, input bit poke);
    wait_idle();
    a = av;
    start = 1'b1;
    expq.push_back(av);
    searches++;
    follow_search(av, poke);
  endtask

  initial begin
    vectors = 0; errors = 0; searches = 0; dones = 0;
    rst = 1'b1; start = 1'b0; a = '0; prev_result = '0;
    #1;
    chk(trial == '0 && !busy && !done && result == '0, "reset_state",
        int'({trial, busy, done, result}), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Directed corner searches
    run_search(W'(9), 1'b0);
    run_search(W'(0), 1'b0);
    run_search(W'(15), 1'b0);

    // Full sweep, with a start pulse mid-search every other time
    for (int v = 0; v < (1 << W); v++) run_search(W'(v), v[0]);

    // Random values with random idle gaps
    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_search(W'($urandom_range(0, (1 << W) - 1)), 1'($urandom_range(0, 1)));
    end

    // start held high: back-to-back searches at WIDTH+1 spacing
    wait_idle();
    start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic [W-1:0] av;
      av = (i < 3) ? W'(5) : W'(10);
      chk(!busy, "b2b_idle_slot", int'(busy), 0);
      a = av;
      expq.push_back(av);
      searches++;
      if (i == 3) begin
        follow_search(av, 1'b0);
      end else begin
        @(posedge clk);
        for (int j = 0; j < int'(W); j++) begin
          @(negedge clk);
          chk(int'(trial) == model_trial(int'(av), int'(W) - 1 - j), "b2b_trial",
              int'(trial), model_trial(int'(av), int'(W) - 1 - j));
        end
        @(negedge clk);
        chk(done && !busy, "b2b_done", int'({done, busy}), 2);
      end
    end
    start = 1'b0;
    @(negedge clk);
    chk(!busy, "no_extra_search", int'(busy), 0);

    // Reset mid-search abandons it without a done pulse
    wait_idle();
    a = W'(6);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk(trial == '0 && !busy && !done && result == '0, "reset_mid_search",
        int'({trial, busy, done, result}), 0);
    @(negedge clk);
    @(negedge clk);
    chk(!done && result == '0, "reset_hold", int'({done, result}), 0);
    rst = 1'b0;
    run_search(W'(6), 1'b0);

    repeat (3) @(negedge clk);
    chk(expq.size() == 0, "scoreboard_empty", expq.size(), 0);
    chk(dones == searches, "done_count", dones, searches);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, vectors %0d", vectors);
    $fatal(1);
  end

endmodule
